moore_hit_monitor: RTL and testbench



---
 rtl/moore_hit_monitor.sv | 142 ++++++++++++++
 tb/tb_moore_hit_monitor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/moore_hit_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : moore_hit_monitor
//  Brief    : Turns Moore detector rises into hit pulses, counts them, measures
//             inter-hit spacing and raises a sticky burst alarm.
//  Revision : 1.0 - initial release
// ============================================================================
module moore_hit_monitor #(
    parameter int CNT_W      = 8,
    parameter int GAP_W      = 8,
    parameter int ALARM_HITS = 3,
    parameter int WINDOW     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             z,
    input  logic             en,
    input  logic             clear,
    output logic             hit,
    output logic [CNT_W-1:0] hit_count,
    output logic [GAP_W-1:0] last_gap,
    output logic             alarm
);

    localparam logic [CNT_W-1:0] c_cnt_max    = '1;
    localparam logic [GAP_W-1:0] c_gap_max    = '1;
    localparam logic [GAP_W-1:0] c_win_last   = GAP_W'(WINDOW - 1);
    localparam logic [3:0]       c_alarm_hits = 4'(ALARM_HITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WATCH = 2'd1,
        ST_ALARM = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_z_prev;
    logic             r_hit;
    logic [CNT_W-1:0] r_hit_count;
    logic [GAP_W-1:0] r_last_gap;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_first_seen;
    logic [GAP_W-1:0] r_win_cnt;
    logic [3:0]       r_burst_hits;
    logic             r_alarm;

    logic             w_rise;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [GAP_W-1:0] w_gap_inc;
    logic [GAP_W-1:0] w_win_inc;
    logic [3:0]       w_burst_next;
    logic             w_win_open;

    assign w_rise       = en & z & ~r_z_prev;
    assign w_cnt_inc    = (r_hit_count == c_cnt_max) ? c_cnt_max : r_hit_count + CNT_W'(1);
    assign w_gap_inc    = (r_gap_cnt == c_gap_max) ? c_gap_max : r_gap_cnt + GAP_W'(1);
    assign w_win_inc    = r_win_cnt + GAP_W'(1);
    assign w_burst_next = r_burst_hits + 4'd1;
    // A rise still belongs to the open burst only up to offset WINDOW-1.
    assign w_win_open   = (r_win_cnt <= c_win_last);

    // z_prev follows z on every edge so a level spanning clear or en=0 is not re-counted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_z_prev <= 1'b0;
        end else begin
            r_z_prev <= z;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_hit        <= 1'b0;
            r_hit_count  <= '0;
            r_last_gap   <= '0;
            r_gap_cnt    <= '0;
            r_first_seen <= 1'b0;
        end else begin
            r_hit <= w_rise;
            if (w_rise) begin
                r_hit_count  <= w_cnt_inc;
                if (r_first_seen) begin
                    r_last_gap <= w_gap_inc;
                end
                r_first_seen <= 1'b1;
                r_gap_cnt    <= '0;
            end else if (en && r_first_seen) begin
                r_gap_cnt <= w_gap_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state      <= ST_IDLE;
            r_win_cnt    <= '0;
            r_burst_hits <= '0;
            r_alarm      <= 1'b0;
        end else if (en) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state      <= ST_WATCH;
                        r_win_cnt    <= GAP_W'(1);
                        r_burst_hits <= 4'd1;
                    end
                end
                ST_WATCH: begin
                    if (w_rise && w_win_open && (w_burst_next == c_alarm_hits)) begin
                        r_state <= ST_ALARM;
                        r_alarm <= 1'b1;
                    end else if (w_rise && w_win_open) begin
                        r_burst_hits <= w_burst_next;
                        r_win_cnt    <= w_win_inc;
                    end else if (w_rise) begin
                        // window already closed: this rise opens a fresh burst
                        r_win_cnt    <= GAP_W'(1);
                        r_burst_hits <= 4'd1;
                    end else if (r_win_cnt >= c_win_last) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_win_cnt <= w_win_inc;
                    end
                end
                ST_ALARM: begin
                    r_alarm <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign hit       = r_hit;
    assign hit_count = r_hit_count;
    assign last_gap  = r_last_gap;
    assign alarm     = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_moore_hit_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_moore_hit_monitor
//  Brief    : Directed + random bench for two parameterisations of the monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_moore_hit_monitor;

    logic       clk = 1'b0;
    logic       rst, z, en, clear;
    logic       hit0, hit1, alarm0, alarm1;
    logic [7:0] cnt0, gap0;
    logic [2:0] cnt1;
    logic [4:0] gap1;

    int n_chk  = 0;
    int n_fail = 0;

    always #20 clk = ~clk;

    moore_hit_monitor u_dut0 (
        .clk(clk), .rst(rst), .z(z), .en(en), .clear(clear),
        .hit(hit0), .hit_count(cnt0), .last_gap(gap0), .alarm(alarm0)
    );

    moore_hit_monitor #(.CNT_W(3), .GAP_W(5), .ALARM_HITS(2), .WINDOW(4)) u_dut1 (
        .clk(clk), .rst(rst), .z(z), .en(en), .clear(clear),
        .hit(hit1), .hit_count(cnt1), .last_gap(gap1), .alarm(alarm1)
    );

    // Reference model: time is counted in enabled edges, bursts are tracked
    // as (start time, number of rises) and gaps as time differences.
    typedef struct {
        bit hit;
        int cnt;
        int gap;
        bit first;
        int t_en;
        int t_last;
        bit active;
        int t0;
        int n;
        bit alarm;
    } mdl_t;

    mdl_t m[2];
    bit   zp;
    int   cmax[2]  = '{255, 7};
    int   gmax[2]  = '{255, 31};
    int   ahits[2] = '{3, 2};
    int   win[2]   = '{8, 4};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit rise;
        if (rst) begin
            zp = 1'b0;
            for (int k = 0; k < 2; k++) m[k] = '{default: 0};
        end else begin
            rise = en & z & ~zp;
            zp   = z;
            for (int k = 0; k < 2; k++) begin
                if (clear) begin
                    m[k] = '{default: 0};
                end else begin
                    m[k].hit = rise;
                    if (en) m[k].t_en++;
                    if (rise) begin
                        if (m[k].cnt < cmax[k]) m[k].cnt++;
                        if (m[k].first)
                            m[k].gap = (m[k].t_en - m[k].t_last > gmax[k]) ? gmax[k]
                                                                           : m[k].t_en - m[k].t_last;
                        m[k].first  = 1'b1;
                        m[k].t_last = m[k].t_en;
                        if (!m[k].alarm) begin
                            if (!m[k].active || (m[k].t_en - m[k].t0 >= win[k])) begin
                                m[k].active = 1'b1;
                                m[k].t0     = m[k].t_en;
                                m[k].n      = 1;
                            end else begin
                                m[k].n++;
                                if (m[k].n >= ahits[k]) m[k].alarm = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic cyc(input bit zv, input bit env, input bit clr, input bit rv);
        z = zv; en = env; clear = clr; rst = rv;
        @(posedge clk);
        model_step();
        #1;
        chk("hit0",   hit0,   m[0].hit);
        chk("cnt0",   cnt0,   m[0].cnt);
        chk("gap0",   gap0,   m[0].gap);
        chk("alarm0", alarm0, m[0].alarm);
        chk("hit1",   hit1,   m[1].hit);
        chk("cnt1",   cnt1,   m[1].cnt);
        chk("gap1",   gap1,   m[1].gap);
        chk("alarm1", alarm1, m[1].alarm);
    endtask

    initial begin
        bit       xs[20] = '{1,0,0,0,0,1,1,1,0,1,1,0,0,1,1,1,1,0,1,1};
        bit [2:0] hist;
        bit       zv;

        // reset held with z high, then released with z still high
        cyc(1, 1, 0, 1);
        cyc(1, 1, 0, 1);
        chk("rst_cnt", cnt0, 0);
        chk("rst_alarm", alarm0, 0);
        cyc(1, 1, 0, 0);
        chk("rst_first_hit", hit0, 1);
        cyc(1, 1, 0, 0);
        chk("rst_single_hit", hit0, 0);
        chk("rst_cnt_one", cnt0, 1);
        chk("rst_gap_zero", gap0, 0);
        cyc(0, 1, 0, 0);

        // spacing: rises at edges 2, 6, 16
        cyc(0, 1, 1, 0);
        for (int e = 0; e < 20; e++) begin
            cyc((e == 2) || (e == 6) || (e == 16), 1, 0, 0);
            if (e == 6)  chk("gap_second", gap0, 4);
            if (e == 16) chk("gap_third", gap0, 10);
        end
        chk("spacing_cnt", cnt0, 3);
        chk("spacing_alarm", alarm0, 0);

        // rises at 0, 3, 6 fall inside one window
        cyc(0, 1, 1, 0);
        for (int e = 0; e < 7; e++) begin
            cyc((e % 3) == 0, 1, 0, 0);
            if (e == 5) chk("alarm_before", alarm0, 0);
        end
        chk("alarm_set", alarm0, 1);
        for (int e = 0; e < 20; e++) cyc(0, 1, 0, 0);
        chk("alarm_sticky", alarm0, 1);

        // rises at 0, 4, 8: window expires before the third
        cyc(0, 1, 1, 0);
        for (int e = 0; e < 12; e++) cyc((e % 4) == 0, 1, 0, 0);
        chk("alarm_outside", alarm0, 0);

        // en low for 5 cycles stretches the window
        cyc(0, 1, 1, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        for (int e = 0; e < 5; e++) cyc(0, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("alarm_extended", alarm0, 1);

        // clear beats a simultaneous rise; level is not re-counted afterwards
        cyc(0, 1, 1, 0);
        cyc(1, 1, 1, 0);
        chk("clear_rise_hit", hit0, 0);
        cyc(1, 1, 0, 0);
        chk("clear_level_hit", hit0, 0);
        chk("clear_cnt", cnt0, 0);
        chk("clear_alarm", alarm0, 0);

        // rise while disabled is lost
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk("en_off_hit", hit0, 0);
        cyc(1, 1, 0, 0);
        chk("en_off_cnt", cnt0, 0);

        // count saturation and gap saturation
        cyc(0, 1, 1, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, 0, 0);
            cyc(0, 1, 0, 0);
        end
        chk("sat_cnt_small", cnt1, 7);
        chk("sat_cnt_wide", cnt0, 10);
        for (int i = 0; i < 300; i++) cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("sat_gap_wide", gap0, 255);
        chk("sat_gap_small", gap1, 31);

        // detector chain: Moore "101" detector, overlapping, Z from state
        cyc(0, 1, 1, 0);
        hist = 3'b000;
        for (int i = 0; i < 20; i++) begin
            zv = (hist == 3'b101);
            cyc(zv, 1, 0, 0);
            hist = {hist[1:0], xs[i]};
        end
        chk("chain_cnt", cnt0, 2);
        chk("chain_gap", gap0, 9);
        chk("chain_alarm", alarm0, 0);

        // randomized traffic against the model
        zv = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) zv = ~zv;
            cyc(zv, $urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0,
                $urandom_range(0, 299) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
